// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and sequencer for a single-port RAM.
// Port 0 is instruction fetch, port 1 is data/loader. A clear engine zero-fills
// the whole RAM after reset (optionally) and on clear_start, so the RAM itself
// needs no bulk reset.
//
// state | meaning
// CLEAR | clear engine writing zeros to every address, busy high
// IDLE  | waiting for clear_start or a port request
// ISSUE | RAM performs the granted access at the end of this cycle
// RESP  | read data from the RAM is captured and returned to the port
module ram_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Clear counter is one bit wider than the address so reaching DEPTH is
  // detected directly instead of wrapping back to address 0.
  localparam logic [ADDR_W:0] CLR_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CLR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
  logic              last_port, last_port_nxt;   // port granted most recently
  logic              cur_port, cur_port_nxt;     // port owning the access in flight
  logic              cur_rd, cur_rd_nxt;         // access in flight is a read

  logic              gnt0_nxt, gnt1_nxt, rvalid0_nxt, rvalid1_nxt;
  logic              busy_nxt, ram_read_nxt, ram_write_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_nxt, rdata_nxt;

  logic              any_req, sel_port, sel_we;

  // On a conflict the port not granted last wins; otherwise the lone requester.
  assign any_req  = req0 | req1;
  assign sel_port = (req0 & req1) ? ~last_port : req1;
  assign sel_we   = sel_port ? we1 : we0;

  // State register with asynchronous reset into CLEAR or IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state <= S_CLEAR;
      else                state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; clear_start beats any request in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_cnt == CLR_END) state_nxt = S_IDLE;
      S_IDLE: begin
        if (clear_start)  state_nxt = S_CLEAR;
        else if (any_req) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and bookkeeping for the current state.
  always_comb begin
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    rvalid0_nxt   = 1'b0;
    rvalid1_nxt   = 1'b0;
    busy_nxt      = 1'b0;
    ram_read_nxt  = 1'b0;
    ram_write_nxt = 1'b0;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    rdata_nxt     = rdata;
    clr_cnt_nxt   = clr_cnt;
    last_port_nxt = last_port;
    cur_port_nxt  = cur_port;
    cur_rd_nxt    = cur_rd;
    case (state)
      S_CLEAR: begin
        if (clr_cnt != CLR_END) begin
          busy_nxt      = 1'b1;
          ram_write_nxt = 1'b1;
          ram_addr_nxt  = clr_cnt[ADDR_W-1:0];
          ram_wdata_nxt = '0;
          clr_cnt_nxt   = clr_cnt + CLR_ONE;
        end else begin
          clr_cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (clear_start) begin
          // Address 0 is written on the entry edge so busy spans exactly DEPTH cycles.
          busy_nxt      = 1'b1;
          ram_write_nxt = 1'b1;
          ram_addr_nxt  = '0;
          ram_wdata_nxt = '0;
          clr_cnt_nxt   = CLR_ONE;
        end else if (any_req) begin
          gnt0_nxt      = ~sel_port;
          gnt1_nxt      = sel_port;
          ram_addr_nxt  = sel_port ? addr1 : addr0;
          ram_wdata_nxt = sel_port ? wdata1 : wdata0;
          ram_read_nxt  = ~sel_we;
          ram_write_nxt = sel_we;
          last_port_nxt = sel_port;
          cur_port_nxt  = sel_port;
          cur_rd_nxt    = ~sel_we;
        end
      end
      S_ISSUE: begin
      end
      S_RESP: begin
        if (cur_rd) begin
          rdata_nxt   = ram_rdata;
          rvalid0_nxt = ~cur_port;
          rvalid1_nxt = cur_port;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and bookkeeping registers; reset drops any access or clear in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      busy      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      clr_cnt   <= '0;
      last_port <= 1'b1;
      cur_port  <= 1'b0;
      cur_rd    <= 1'b0;
    end else begin
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      rvalid0   <= rvalid0_nxt;
      rvalid1   <= rvalid1_nxt;
      busy      <= busy_nxt;
      ram_read  <= ram_read_nxt;
      ram_write <= ram_write_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      rdata     <= rdata_nxt;
      clr_cnt   <= clr_cnt_nxt;
      last_port <= last_port_nxt;
      cur_port  <= cur_port_nxt;
      cur_rd    <= cur_rd_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural 256x8 RAM, a shadow-memory reference
// model with a round-robin pointer, a table of directed accesses, hand-written
// clear/reset sequences and randomized request batches.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0, req1, we0, we1, clear_start;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write;
  logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .clear_start(clear_start), .busy(busy),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM, filled with nonzero garbage so the clear is observable.
  logic [7:0] mem [256];
  bit         mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom_range(1, 255));
      mem_init <= 1'b1;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      if (ram_read)  ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write,
                ram_addr, ram_wdata, rdata});
  endfunction

  // Reference model: shadow memory, last granted port, last read value.
  logic [7:0] ref_mem [256];
  logic       ref_last;
  logic [7:0] ref_rdata;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic model_reset();
    model_clear();
    ref_last  = 1'b1;
    ref_rdata = 8'h00;
  endtask

  // Serves a batch of simultaneous requests in round-robin order.
  task automatic model_batch(input logic [1:0] mask, input logic [1:0] we,
                             input logic [1:0][7:0] a, input logic [1:0][7:0] w,
                             output int first, output logic [1:0][7:0] rd);
    int p;
    rd = '0;
    if (mask == 2'b11) first = ref_last ? 0 : 1;
    else               first = mask[1] ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : 1 - first;
      if (mask[p]) begin
        if (we[p]) ref_mem[a[p]] = w[p];
        else begin
          rd[p]     = ref_mem[a[p]];
          ref_rdata = rd[p];
        end
        ref_last = (p == 1);
      end
    end
  endtask

  // Raises the requests together and checks the exact gnt/rvalid timeline.
  task automatic run_batch(input logic [1:0] mask, input logic [1:0] we,
                           input logic [1:0][7:0] a, input logic [1:0][7:0] w,
                           input int first, input logic [1:0][7:0] rd,
                           input string tag);
    int         gc [2];
    logic [3:0] exp_v, got_v;
    gc[first]     = 1;
    gc[1 - first] = mask[1 - first] ? 4 : -10;
    req0 = mask[0]; we0 = we[0]; addr0 = a[0]; wdata0 = w[0];
    req1 = mask[1]; we1 = we[1]; addr1 = a[1]; wdata1 = w[1];
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_v = '0;
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          if (c == gc[p]) exp_v[p] = 1'b1;
          if (!we[p] && c == gc[p] + 2) exp_v[2 + p] = 1'b1;
        end
      end
      got_v = {rvalid1, rvalid0, gnt1, gnt0};
      chk($sformatf("%s c%0d {rv1,rv0,g1,g0}", tag, c), 32'(got_v), 32'(exp_v));
      for (int p = 0; p < 2; p++)
        if (exp_v[2 + p]) chk($sformatf("%s rdata port%0d", tag, p), 32'(rdata), 32'(rd[p]));
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk($sformatf("%s rdata hold", tag), 32'(rdata), 32'(ref_rdata));
  endtask

  task automatic random_batch(input string tag);
    logic [1:0]      mask, we;
    logic [1:0][7:0] a, w, rd;
    int              first;
    mask = 2'($urandom_range(1, 3));
    we   = 2'($urandom_range(0, 3));
    a    = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
    w    = {8'($urandom), 8'($urandom)};
    model_batch(mask, we, a, w, first, rd);
    run_batch(mask, we, a, w, first, rd, tag);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]      mask;
    logic [1:0]      we;
    logic [1:0][7:0] a;
    logic [1:0][7:0] w;
    int              first;
    logic [1:0][7:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] mask, input logic we0_i, input logic we1_i,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input int first, input logic [7:0] rd0, input logic [7:0] rd1);
    vec_t v;
    v.mask = mask; v.we = {we1_i, we0_i}; v.a = {a1, a0}; v.w = {w1, w0};
    v.first = first; v.rd = {rd1, rd0};
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    int              cnt, bad, mfirst;
    logic [1:0][7:0] mrd;

    tbl[0] = mk(2'b10, 1'b0, 1'b1, 8'h00, 8'h10, 8'h00, 8'hA5, 1, 8'h00, 8'h00);
    tbl[1] = mk(2'b01, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 8'h00);
    tbl[2] = mk(2'b10, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h11, 1, 8'h00, 8'h00);
    tbl[3] = mk(2'b11, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 0, 8'h11, 8'h00);
    tbl[4] = mk(2'b11, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 0, 8'h11, 8'h00);
    tbl[5] = mk(2'b11, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 8'hFF);
    tbl[6] = mk(2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    tbl[7] = mk(2'b11, 1'b0, 1'b1, 8'h10, 8'h10, 8'h00, 8'h5A, 1, 8'h5A, 8'h00);
    tbl[8] = mk(2'b10, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'hFF);

    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; clear_start = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

    // Reset values, then the power-up clear sweep.
    repeat (3) @(negedge clk);
    chk("reset outputs", all_outs(), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      chk($sformatf("clear sweep k%0d", k),
          32'({busy, ram_write, ram_read, ram_wdata, ram_addr}),
          32'({1'b1, 1'b1, 1'b0, 8'h00, 8'(k - 1)}));
    end
    @(negedge clk);
    chk("clear end busy", 32'(busy), 32'h0);
    chk("clear end no wrap write", 32'(ram_write), 32'h0);
    model_reset();

    // Directed accesses.
    for (int i = 0; i < 9; i++) begin
      model_batch(tbl[i].mask, tbl[i].we, tbl[i].a, tbl[i].w, mfirst, mrd);
      run_batch(tbl[i].mask, tbl[i].we, tbl[i].a, tbl[i].w, tbl[i].first, tbl[i].rd,
                $sformatf("vec%0d", i));
    end

    // clear_start and req0 together: clear wins, req0 served once busy falls.
    clear_start = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    @(negedge clk);
    clear_start = 1'b0;
    chk("cs entry busy/write/addr", 32'({busy, ram_write, ram_addr}), 32'({1'b1, 1'b1, 8'h00}));
    cnt = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      cnt++;
      if (gnt0 || gnt1) bad++;
      @(negedge clk);
    end
    chk("cs busy cycles", 32'(cnt), 32'd256);
    chk("cs gnt while busy", 32'(bad), 32'd0);
    chk("cs gnt0 at busy fall", 32'(gnt0), 32'h0);
    model_clear();
    @(negedge clk);
    chk("cs gnt0 after clear", 32'({gnt1, gnt0}), 32'h1);
    req0 = 1'b0;
    ref_last = 1'b0;
    @(negedge clk);
    chk("cs rvalid0 early", 32'(rvalid0), 32'h0);
    @(negedge clk);
    chk("cs rvalid0", 32'({rvalid1, rvalid0}), 32'h1);
    chk("cs rdata cleared", 32'(rdata), 32'h00);
    ref_rdata = 8'h00;

    for (int i = 0; i < 60; i++) random_batch($sformatf("rnd%0d", i));

    // Reset during RESP of a read drops the response and restarts the clear.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    @(negedge clk);
    chk("rst-seq gnt1", 32'(gnt1), 32'h1);
    req1 = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst-seq async outputs", all_outs(), 32'h0);
    @(negedge clk);
    chk("rst-seq no rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst-seq clear restart", 32'({busy, ram_write, ram_addr}), 32'({1'b1, 1'b1, 8'h00}));
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    chk("rst-seq busy cycles", 32'(cnt), 32'd256);
    @(negedge clk);

    // Pointer is back to favouring port 0 after reset.
    model_batch(2'b11, 2'b00, {8'h02, 8'h10}, 16'h0, mfirst, mrd);
    run_batch(2'b11, 2'b00, {8'h02, 8'h10}, 16'h0, 0, 16'h0, "post-rst conflict");
    for (int i = 0; i < 10; i++) random_batch($sformatf("rnd_post%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
